// File: rtl/adc_frame_tagger.sv
// Frames the merged ADC word stream per trigger: header with frame counter, capped data words,
// trailer with word count and overflow flag. Single clock, 2-entry output skid buffer.
module adc_frame_tagger #(
  parameter int         DATA_WIDTH  = 32,
  parameter logic [3:0] HEADER_MARK = 4'h5,
  parameter int         MAX_WORDS   = 1024
) (
  input  logic                  BUS_CLK,
  input  logic                  BUS_RST,
  input  logic                  ENABLE,
  input  logic                  TRIGGER,
  input  logic                  IN_VALID,
  input  logic [DATA_WIDTH-1:0] IN_DATA,
  output logic                  IN_READY,
  output logic                  OUT_VALID,
  output logic [DATA_WIDTH-1:0] OUT_DATA,
  input  logic                  OUT_READY,
  output logic [23:0]           FRAME_CNT,
  output logic [15:0]           DROP_CNT,
  output logic [7:0]            TRIG_MISS_CNT,
  output logic                  BUSY
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_HEADER,
    S_PASS,
    S_TRAILER
  } state_t;

  localparam logic [15:0] MAX_CNT = 16'(MAX_WORDS);

  state_t                state, state_n;
  logic                  trig_q, trig_q2, trig_event;
  logic                  pend, pend_n;
  logic                  close_trig, close_trig_n;
  logic [15:0]           word_cnt, word_cnt_n;
  logic                  ovf, ovf_n;
  logic [23:0]           frame_cnt, frame_cnt_n;
  logic [15:0]           drop_cnt;
  logic [7:0]            miss_cnt;
  logic                  drop_inc, miss_inc;
  logic                  ready_q;

  logic [DATA_WIDTH-1:0] buf_mem [2];
  logic                  wr_ptr, rd_ptr;
  logic [1:0]            buf_cnt, buf_cnt_n;
  logic                  push, pop, space, accept;
  logic [DATA_WIDTH-1:0] push_data;

  assign trig_event = trig_q & ~trig_q2;
  assign accept     = IN_VALID & ready_q;
  assign pop        = (buf_cnt != 2'd0) & OUT_READY;
  assign space      = (buf_cnt != 2'd2) | pop;
  assign buf_cnt_n  = buf_cnt + {1'b0, push} - {1'b0, pop};

  always_comb begin
    // NOTE: every signal gets a default first so no path through the case infers a latch.
    state_n      = state;
    pend_n       = pend;
    close_trig_n = close_trig;
    word_cnt_n   = word_cnt;
    ovf_n        = ovf;
    frame_cnt_n  = frame_cnt;
    drop_inc     = 1'b0;
    miss_inc     = 1'b0;
    push         = 1'b0;
    push_data    = '0;

    unique case (state)
      S_IDLE: begin
        if (accept) drop_inc = 1'b1;
        if (trig_event || pend) begin
          pend_n = pend & trig_event;
          if (ENABLE) state_n = S_HEADER;
        end
      end
      S_HEADER: begin
        if (trig_event && ENABLE) begin
          if (!pend) pend_n = 1'b1;
          else       miss_inc = 1'b1;
        end
        if (space) begin
          push        = 1'b1;
          push_data   = {HEADER_MARK, 4'h0, frame_cnt};
          frame_cnt_n = frame_cnt + 24'd1;
          word_cnt_n  = '0;
          ovf_n       = 1'b0;
          state_n     = S_PASS;
        end
      end
      S_PASS: begin
        if (accept) begin
          if (word_cnt < MAX_CNT) begin
            push       = 1'b1;
            push_data  = IN_DATA;
            word_cnt_n = word_cnt + 16'd1;
          end else begin
            drop_inc = 1'b1;
            ovf_n    = 1'b1;
          end
        end
        // A pending trigger left over from HEADER closes the frame just like a fresh edge.
        if (trig_event || pend || !ENABLE) begin
          state_n      = S_TRAILER;
          close_trig_n = trig_event | pend;
          pend_n       = pend & trig_event;
        end
      end
      S_TRAILER: begin
        if (trig_event && ENABLE) begin
          if (!pend) pend_n = 1'b1;
          else       miss_inc = 1'b1;
        end
        if (space) begin
          push      = 1'b1;
          push_data = {HEADER_MARK, 1'b1, ovf, 10'h0, word_cnt};
          state_n   = (close_trig && ENABLE) ? S_HEADER : S_IDLE;
        end
      end
      default: state_n = S_IDLE;
    endcase

    if (!ENABLE) pend_n = 1'b0;
  end

  always_ff @(posedge BUS_CLK) begin
    if (BUS_RST) begin
      state      <= S_IDLE;
      trig_q     <= 1'b0;
      trig_q2    <= 1'b0;
      pend       <= 1'b0;
      close_trig <= 1'b0;
      word_cnt   <= '0;
      ovf        <= 1'b0;
      frame_cnt  <= '0;
      drop_cnt   <= '0;
      miss_cnt   <= '0;
      ready_q    <= 1'b0;
      // NOTE: the two buffer entries are reset because OUT_DATA must read zero out of reset.
      buf_mem[0] <= '0;
      buf_mem[1] <= '0;
      wr_ptr     <= 1'b0;
      rd_ptr     <= 1'b0;
      buf_cnt    <= '0;
    end else begin
      state      <= state_n;
      trig_q     <= TRIGGER;
      trig_q2    <= trig_q;
      pend       <= pend_n;
      close_trig <= close_trig_n;
      word_cnt   <= word_cnt_n;
      ovf        <= ovf_n;
      frame_cnt  <= frame_cnt_n;
      if (drop_inc && drop_cnt != '1) drop_cnt <= drop_cnt + 16'd1;
      if (miss_inc && miss_cnt != '1) miss_cnt <= miss_cnt + 8'd1;
      // Registered ready: only grant a slot the buffer is guaranteed to have next cycle.
      ready_q    <= (state_n == S_IDLE) || (state_n == S_PASS && buf_cnt_n != 2'd2);
      if (push) begin
        buf_mem[wr_ptr] <= push_data;
        wr_ptr          <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      buf_cnt    <= buf_cnt_n;
    end
  end

  assign IN_READY      = ready_q;
  assign OUT_VALID     = (buf_cnt != 2'd0);
  assign OUT_DATA      = buf_mem[rd_ptr];
  assign FRAME_CNT     = frame_cnt;
  assign DROP_CNT      = drop_cnt;
  assign TRIG_MISS_CNT = miss_cnt;
  assign BUSY          = (state != S_IDLE) || (buf_cnt != 2'd0);

endmodule

// File: tb/tb_adc_frame_tagger.sv
// Scoreboard bench for adc_frame_tagger: a spec-level frame model pushes expected words,
// a negedge monitor pops and compares every word the DUT hands downstream.
module tb_adc_frame_tagger;

  localparam int MAXW  = 4;
  localparam int LIMIT = 2000;

  logic        BUS_CLK = 1'b0;
  logic        BUS_RST = 1'b1;
  logic        ENABLE = 1'b0;
  logic        TRIGGER = 1'b0;
  logic        IN_VALID = 1'b0;
  logic [31:0] IN_DATA = '0;
  logic        IN_READY;
  logic        OUT_VALID;
  logic [31:0] OUT_DATA;
  logic        OUT_READY = 1'b0;
  logic [23:0] FRAME_CNT;
  logic [15:0] DROP_CNT;
  logic [7:0]  TRIG_MISS_CNT;
  logic        BUSY;

  adc_frame_tagger #(
    .DATA_WIDTH (32),
    .HEADER_MARK(4'h5),
    .MAX_WORDS  (MAXW)
  ) dut (
    .BUS_CLK      (BUS_CLK),
    .BUS_RST      (BUS_RST),
    .ENABLE       (ENABLE),
    .TRIGGER      (TRIGGER),
    .IN_VALID     (IN_VALID),
    .IN_DATA      (IN_DATA),
    .IN_READY     (IN_READY),
    .OUT_VALID    (OUT_VALID),
    .OUT_DATA     (OUT_DATA),
    .OUT_READY    (OUT_READY),
    .FRAME_CNT    (FRAME_CNT),
    .DROP_CNT     (DROP_CNT),
    .TRIG_MISS_CNT(TRIG_MISS_CNT),
    .BUSY         (BUSY)
  );

  initial forever #5 BUS_CLK = ~BUS_CLK;

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [31:0] exp_q[$];
  logic [31:0] last_out = '0;

  // Frame model state.
  int          m_frame = 0;
  int          m_wc = 0;
  bit          m_ovf = 0;
  bit          m_in_frame = 0;
  int          m_drop = 0;
  int          m_miss = 0;

  // 0: OUT_READY=1, 1: random, 2: OUT_READY=0
  int          rdy_mode = 2;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] hdr_word(input int frame);
    return {4'h5, 4'h0, 24'(frame)};
  endfunction

  function automatic logic [31:0] trl_word(input bit ovf, input int wc);
    return {4'h5, 1'b1, ovf, 10'h0, 16'(wc)};
  endfunction

  initial forever begin
    @(posedge BUS_CLK);
    #1;
    case (rdy_mode)
      0:       OUT_READY = 1'b1;
      1:       OUT_READY = 1'($urandom_range(0, 1));
      default: OUT_READY = 1'b0;
    endcase
  end

  initial forever begin
    @(negedge BUS_CLK);
    if (!BUS_RST && OUT_VALID && OUT_READY) begin
      last_out = OUT_DATA;
      if (exp_q.size() == 0) check("spurious_out", {31'b0, OUT_VALID}, 32'd0);
      else                   check("out_word", OUT_DATA, exp_q.pop_front());
    end
  end

  initial begin
    #500_000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge BUS_CLK);
      #1;
    end
  endtask

  task automatic wait_ready(input logic v);
    bit done = 0;
    for (int k = 0; k < LIMIT; k++) begin
      @(negedge BUS_CLK);
      if (IN_READY == v) begin
        done = 1;
        break;
      end
    end
    if (!done) check("in_ready_wait", {31'b0, IN_READY}, {31'b0, v});
    @(posedge BUS_CLK);
    #1;
  endtask

  task automatic model_accept(input logic [31:0] d);
    if (m_in_frame) begin
      if (m_wc < MAXW) begin
        exp_q.push_back(d);
        m_wc++;
      end else begin
        m_ovf = 1;
        m_drop++;
      end
    end else begin
      m_drop++;
    end
  endtask

  task automatic send_word(input logic [31:0] d);
    bit done = 0;
    IN_VALID = 1'b1;
    IN_DATA  = d;
    for (int k = 0; k < LIMIT; k++) begin
      @(negedge BUS_CLK);
      if (IN_READY) begin
        done = 1;
        break;
      end
    end
    if (!done) check("in_ready_timeout", {31'b0, IN_READY}, 32'd1);
    else       model_accept(d);
    @(posedge BUS_CLK);
    #1;
  endtask

  task automatic drain();
    for (int k = 0; k < 5 * LIMIT; k++) begin
      if (exp_q.size() == 0) break;
      @(posedge BUS_CLK);
      #1;
    end
    check("drain", 32'(exp_q.size()), 32'd0);
    idle(1);
  endtask

  // Expects IN_VALID low and an empty output buffer; opens or rolls a frame.
  task automatic trigger_open();
    if (m_in_frame) exp_q.push_back(trl_word(m_ovf, m_wc));
    exp_q.push_back(hdr_word(m_frame));
    m_frame++;
    m_wc       = 0;
    m_ovf      = 0;
    m_in_frame = 1;
    TRIGGER = 1'b1;
    idle(1);
    TRIGGER = 1'b0;
    wait_ready(1'b0);
    wait_ready(1'b1);
  endtask

  task automatic close_frame();
    exp_q.push_back(trl_word(m_ovf, m_wc));
    m_in_frame = 0;
    ENABLE = 1'b0;
    idle(1);
    ENABLE = 1'b1;
    wait_ready(1'b0);
    wait_ready(1'b1);
  endtask

  initial begin
    ENABLE = 1'b1;
    idle(3);
    check("rst_in_ready",  {31'b0, IN_READY},  32'd0);
    check("rst_out_valid", {31'b0, OUT_VALID}, 32'd0);
    check("rst_out_data",  OUT_DATA,            32'd0);
    check("rst_frame_cnt", {8'b0, FRAME_CNT},   32'd0);
    check("rst_drop_cnt",  {16'b0, DROP_CNT},   32'd0);
    check("rst_miss_cnt",  {24'b0, TRIG_MISS_CNT}, 32'd0);
    check("rst_busy",      {31'b0, BUSY},       32'd0);
    BUS_RST = 1'b0;
    idle(1);
    check("post_rst_in_ready", {31'b0, IN_READY}, 32'd1);
    rdy_mode = 0;

    // Words outside any frame are dropped.
    for (int i = 0; i < 5; i++) send_word(32'hD000_0000 + 32'(i));
    IN_VALID = 1'b0;
    idle(3);
    check("idle_out_valid", {31'b0, OUT_VALID}, 32'd0);
    check("idle_drop_cnt",  {16'b0, DROP_CNT},  32'd5);

    // Basic frame then roll to a second frame.
    trigger_open();
    send_word(32'hAAAA_0001);
    send_word(32'hBBBB_0002);
    send_word(32'hCCCC_0003);
    IN_VALID = 1'b0;
    drain();
    trigger_open();
    drain();
    check("roll_header", last_out, 32'h5000_0001);
    close_frame();
    drain();
    check("basic_frame_cnt", {8'b0, FRAME_CNT}, 32'd2);

    // Overflow past MAX_WORDS closed by ENABLE low.
    trigger_open();
    for (int i = 0; i < 6; i++) send_word(32'h1234_0000 + 32'(i));
    IN_VALID = 1'b0;
    drain();
    close_frame();
    drain();
    check("ovf_trailer",  last_out,             32'h5C00_0004);
    check("ovf_drop_cnt", {16'b0, DROP_CNT},   32'd7);
    check("ovf_idle_busy", {31'b0, BUSY},      32'd0);

    // Random downstream backpressure across many frames.
    rdy_mode = 1;
    for (int f = 0; f < 20; f++) begin
      int n;
      drain();
      trigger_open();
      n = $urandom_range(0, 7);
      for (int w = 0; w < n; w++) begin
        send_word($urandom);
        if ($urandom_range(0, 3) == 0) begin
          IN_VALID = 1'b0;
          idle(1);
        end
      end
      IN_VALID = 1'b0;
      drain();
      if ($urandom_range(0, 1) == 1) begin
        close_frame();
        send_word($urandom);
        IN_VALID = 1'b0;
      end
    end
    drain();
    if (m_in_frame) close_frame();
    drain();
    check("rand_drop_cnt",  {16'b0, DROP_CNT},  32'(m_drop));
    check("rand_frame_cnt", {8'b0, FRAME_CNT},  32'(m_frame));

    // Three trigger edges while the trailer is stalled.
    rdy_mode = 0;
    idle(2);
    trigger_open();
    drain();
    rdy_mode = 2;
    idle(2);
    send_word(32'h7777_0001);
    send_word(32'h7777_0002);
    IN_VALID = 1'b0;
    exp_q.push_back(trl_word(m_ovf, m_wc));
    m_in_frame = 0;
    ENABLE = 1'b0;
    idle(1);
    ENABLE = 1'b1;
    repeat (3) begin
      TRIGGER = 1'b1;
      idle(1);
      TRIGGER = 1'b0;
      idle(1);
    end
    m_miss += 2;
    exp_q.push_back(hdr_word(m_frame));
    m_frame++;
    m_wc = 0;
    m_ovf = 0;
    m_in_frame = 1;
    idle(2);
    check("miss_cnt", {24'b0, TRIG_MISS_CNT}, 32'd2);
    check("stall_busy", {31'b0, BUSY}, 32'd1);
    rdy_mode = 0;
    drain();
    idle(5);
    close_frame();
    drain();
    check("miss_trailer",   last_out,           32'h5800_0000);
    check("miss_frame_cnt", {8'b0, FRAME_CNT},  32'(m_frame));
    check("miss_cnt_final", {24'b0, TRIG_MISS_CNT}, 32'(m_miss));

    // Reset in the middle of a frame with two words buffered.
    rdy_mode = 2;
    idle(2);
    trigger_open();
    send_word(32'h9999_0001);
    IN_VALID = 1'b0;
    BUS_RST = 1'b1;
    idle(1);
    check("mid_rst_out_valid", {31'b0, OUT_VALID}, 32'd0);
    check("mid_rst_frame_cnt", {8'b0, FRAME_CNT},  32'd0);
    check("mid_rst_drop_cnt",  {16'b0, DROP_CNT},  32'd0);
    check("mid_rst_busy",      {31'b0, BUSY},      32'd0);
    check("mid_rst_in_ready",  {31'b0, IN_READY},  32'd0);
    exp_q.delete();
    m_frame = 0;
    m_wc = 0;
    m_ovf = 0;
    m_in_frame = 0;
    m_drop = 0;
    m_miss = 0;
    BUS_RST = 1'b0;
    rdy_mode = 0;
    idle(2);
    check("mid_rst_ready_back", {31'b0, IN_READY}, 32'd1);
    trigger_open();
    drain();
    check("post_rst_header", last_out, 32'h5000_0000);
    close_frame();
    drain();
    check("final_queue", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
